uart_rx: RTL and testbench
==========================

# uart_rx

Serial receiver for the UART_CRC link: deserialises frames produced by the block's transmitter counterpart (start, 8 data bits LSB-first, parity, optional 8-bit CRC, stop) from an oversampled line. It sits between the external RX pin and the register/interrupt logic. It delivers one byte per frame with parity, CRC and framing status, plus a one-cycle interrupt pulse.

## Interface
- OVERSAMPLE, 16: `sample_tick_i` pulses per bit period; even, minimum 8.
- PARITY_ODD, 0: 0 = even parity, 1 = odd parity, over the 8 data bits.

- clk_i  input  1  system clock
- rst_i  input  1  reset; asynchronous, active-low
- rx_i  input  1  serial line, idle high, asynchronous to clk_i
- sample_tick_i  input  1  single-cycle enable at OVERSAMPLE × baud
- crc_en_i  input  1  frame carries 8 CRC bits after parity; sampled at start-bit confirmation
- data_o  output  8  last received byte; held until next frame completes
- parity_err_o  output  1  parity mismatch on last frame; held with data_o
- crc_err_o  output  1  nonzero CRC residue on last frame; 0 when CRC disabled; held
- frame_err_o  output  1  stop bit sampled low on last frame; held
- rx_busy_o  output  1  high from start-bit confirmation until frame end
- rx_int_o  output  1  one-clk pulse at frame end; status outputs valid in the same cycle

## Operation
- `rx_i` passes through a 2-FF synchroniser. Both flops reset to 1.
- Tick counter: `$clog2(OVERSAMPLE)` bits, advances only on `sample_tick_i`.
- FSM states: IDLE, START, DATA, PARITY, CRC, STOP.
- IDLE: a synchronised high-to-low transition enters START with the tick counter cleared. A line that stays low after a frame error does not restart.
- START: at tick OVERSAMPLE/2−1, samples the line.
  - High: false start; return to IDLE with no pulse and no status change.
  - Low: latch crc_en_i, set rx_busy_o, enter DATA with the counter cleared.
- Bit sampling: every subsequent bit is sampled when the counter reaches OVERSAMPLE−1, i.e. mid-bit.
- DATA: 8 samples, shifted in LSB-first. A 5-bit bit_cnt tracks position and wraps to 0 at each state change. Each data bit also feeds the CRC register.
- PARITY: 1 sample. `parity_err = ^data ^ sample ^ PARITY_ODD`. Next state is CRC if crc_en was latched, else STOP.
- CRC: 8 samples, fed to the CRC register MSB-first. `crc_err = (crc_reg != 0)` after the 8th bit.
  - CRC register: CRC-8, polynomial 0x07, init 0x00 at start confirmation.
  - Serial update: `fb = crc[7] ^ bit; crc = {crc[6:0],0} ^ (fb ? 0x07 : 0)`.
- STOP: 1 sample; frame_err = ~sample.
  - Next clk: update data_o and all error flags, pulse rx_int_o, clear rx_busy_o, return to IDLE.
  - Outputs update even when an error flag is set.
- Simultaneous events: a new falling edge in the same cycle as the rx_int_o pulse is not missed. The edge detector compares with the previous synchronised value, and that value is tracked in every state.
- sample_tick_i stuck low freezes the FSM; no timeout.

## Timing
- Reset values: data_o=0x00, parity_err_o=0, crc_err_o=0, frame_err_o=0, rx_busy_o=0, rx_int_o=0. FSM IDLE, counters 0, CRC 0x00.
- Reset is effective immediately, including mid-frame. A partial frame is discarded with no rx_int_o.
- Input latency: 2 clk synchroniser plus 1 clk edge detect.
- Frame end: rx_int_o rises 1 clk after the sample_tick_i that samples the stop bit. It is high for exactly 1 clk.
- Frame length in bit periods: 11 without CRC, 19 with CRC.
- rx_busy_o rises 1 clk after the start-confirm tick.
- Back-to-back frames with zero idle bits are received without loss.

## Configuration
- `UART_RX_MAJORITY_EN` defined: each bit value is the 2-of-3 majority of samples at counter OVERSAMPLE/2−2, −1 and 0 relative to mid-bit. Start confirmation uses the same vote.
- Undefined: single sample at mid-bit as described above; no vote logic is generated.

## Test plan
- 0xA5, even parity bit 0, stop 1, crc_en_i=0 → one rx_int_o, data_o=0xA5, all errors 0.
- 0x31 followed by CRC 0x97 (correct CRC-8/0x07), crc_en_i=1 → data_o=0x31, crc_err_o=0. Same frame with CRC 0x96 → crc_err_o=1.
- 0x01 with parity bit 0 under even parity → parity_err_o=1, data_o=0x01, rx_int_o pulses.
- 0x55 with stop bit 0 and line held low for 3 bit periods → frame_err_o=1. No second frame until the line returns high and falls again.
- Low glitch of 4 ticks (less than OVERSAMPLE/2) on idle line → no rx_busy_o, no rx_int_o.
- rst_i low during DATA bit 4 → all outputs at reset values. A following clean 0x3C frame is received correctly.
- `UART_RX_MAJORITY_EN` build: 1-tick inverted glitch at mid-bit on every data bit of 0xC3 → data_o=0xC3. Non-majority build → corrupted data.

Source files
------------

// File: rtl/uart_rx.sv
// uart_rx: oversampled UART receiver (start, 8 data LSB-first, parity,
//   optional CRC-8 byte, stop) with held status and one-clk interrupt.
// Ports: clk_i, rst_i (async active-low), rx_i, sample_tick_i, crc_en_i;
//   data_o, parity_err_o, crc_err_o, frame_err_o, rx_busy_o, rx_int_o.
// Optional: define UART_RX_MAJORITY_EN for 2-of-3 sample voting.
module uart_rx #(
   parameter int OVERSAMPLE = 16,
   parameter bit PARITY_ODD = 1'b0
) (
   input  logic       clk_i,
   input  logic       rst_i,
   input  logic       rx_i,
   input  logic       sample_tick_i,
   input  logic       crc_en_i,
   output logic [7:0] data_o,
   output logic       parity_err_o,
   output logic       crc_err_o,
   output logic       frame_err_o,
   output logic       rx_busy_o,
   output logic       rx_int_o
);
   localparam int CW = $clog2(OVERSAMPLE);
   localparam logic [CW-1:0] HALF_M1 = CW'(OVERSAMPLE / 2 - 1);
   localparam logic [CW-1:0] FULL_M1 = CW'(OVERSAMPLE - 1);

   typedef enum logic [2:0] {
      S_IDLE, S_START, S_DATA, S_PAR, S_CRC, S_STOP
   } state_t;

   state_t        state_q;
   logic          sync1_q, sync2_q, prev_q;
   logic [CW-1:0] tick_q;
   logic [4:0]    bit_cnt_q;
   logic [7:0]    shift_q, crc_q, data_q;
   logic          crc_on_q, par_q;
   logic          parity_err_q, crc_err_q, frame_err_q;
   logic          busy_q, int_q;
   logic          fall, hit, smp, bit_val;
   logic [7:0]    shift_d, crc_d;

   function automatic logic [7:0] crc_step(input logic [7:0] c,
                                           input logic b);
      return {c[6:0], 1'b0} ^ ((c[7] ^ b) ? 8'h07 : 8'h00);
   endfunction

   // CRC of the byte in natural MSB-first order, as the transmitter
   // computes it; the received CRC bits then drive the residue to zero.
   function automatic logic [7:0] crc_byte(input logic [7:0] d);
      logic [7:0] c;
      c = 8'h00;
      for (int i = 7; i >= 0; i--) c = crc_step(c, d[i]);
      return c;
   endfunction

`ifdef UART_RX_MAJORITY_EN
   // Two previous tick samples; vote with the current one.
   logic [1:0] vote_q;

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         vote_q <= 2'b11;
      end else if (sample_tick_i) begin
         vote_q <= {vote_q[0], sync2_q};
      end
   end

   assign bit_val = (vote_q[1] & vote_q[0]) |
                    ((vote_q[1] | vote_q[0]) & sync2_q);
`else
   assign bit_val = sync2_q;
`endif

   // prev_q follows the line in every state so an edge in the
   // frame-end cycle is still seen.
   assign fall    = prev_q & ~sync2_q;
   assign hit     = (state_q == S_START) ? (tick_q == HALF_M1)
                                         : (tick_q == FULL_M1);
   assign smp     = sample_tick_i & hit & (state_q != S_IDLE);
   assign shift_d = {bit_val, shift_q[7:1]};
   assign crc_d   = crc_step(crc_q, bit_val);

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         state_q      <= S_IDLE;
         sync1_q      <= 1'b1;
         sync2_q      <= 1'b1;
         prev_q       <= 1'b1;
         tick_q       <= '0;
         bit_cnt_q    <= '0;
         shift_q      <= '0;
         crc_q        <= '0;
         data_q       <= '0;
         crc_on_q     <= 1'b0;
         par_q        <= 1'b0;
         parity_err_q <= 1'b0;
         crc_err_q    <= 1'b0;
         frame_err_q  <= 1'b0;
         busy_q       <= 1'b0;
         int_q        <= 1'b0;
      end else begin
         sync1_q <= rx_i;
         sync2_q <= sync1_q;
         prev_q  <= sync2_q;
         int_q   <= 1'b0;

         if (state_q == S_IDLE) begin
            tick_q <= '0;
         end else if (sample_tick_i) begin
            tick_q <= hit ? '0 : tick_q + CW'(1);
         end

         unique case (state_q)
            S_IDLE: begin
               if (fall) state_q <= S_START;
            end
            S_START: begin
               if (smp) begin
                  if (bit_val) begin
                     state_q <= S_IDLE;
                  end else begin
                     state_q   <= S_DATA;
                     crc_on_q  <= crc_en_i;
                     busy_q    <= 1'b1;
                     crc_q     <= 8'h00;
                     bit_cnt_q <= '0;
                  end
               end
            end
            S_DATA: begin
               if (smp) begin
                  shift_q   <= shift_d;
                  bit_cnt_q <= bit_cnt_q + 5'd1;
                  if (bit_cnt_q == 5'd7) begin
                     state_q   <= S_PAR;
                     bit_cnt_q <= '0;
                     crc_q     <= crc_byte(shift_d);
                  end
               end
            end
            S_PAR: begin
               if (smp) begin
                  par_q   <= ^shift_q ^ bit_val ^ PARITY_ODD;
                  state_q <= crc_on_q ? S_CRC : S_STOP;
               end
            end
            S_CRC: begin
               if (smp) begin
                  crc_q     <= crc_d;
                  bit_cnt_q <= bit_cnt_q + 5'd1;
                  if (bit_cnt_q == 5'd7) begin
                     state_q   <= S_STOP;
                     bit_cnt_q <= '0;
                  end
               end
            end
            S_STOP: begin
               if (smp) begin
                  data_q       <= shift_q;
                  parity_err_q <= par_q;
                  crc_err_q    <= crc_on_q & (|crc_q);
                  frame_err_q  <= ~bit_val;
                  busy_q       <= 1'b0;
                  int_q        <= 1'b1;
                  state_q      <= S_IDLE;
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign data_o       = data_q;
   assign parity_err_o = parity_err_q;
   assign crc_err_o    = crc_err_q;
   assign frame_err_o  = frame_err_q;
   assign rx_busy_o    = busy_q;
   assign rx_int_o     = int_q;

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: randomized + directed frames for uart_rx, with a
//   scoreboard queue checked by an rx_int_o monitor.
module tb_uart_rx;
   localparam int OS   = 16;
   localparam int TDIV = 4;
   localparam bit ODD  = 1'b0;

   logic       clk_i = 1'b0;
   logic       rst_i = 1'b0;
   logic       rx_i = 1'b1;
   logic       sample_tick_i = 1'b0;
   logic       crc_en_i = 1'b0;
   logic [7:0] data_o;
   logic       parity_err_o, crc_err_o, frame_err_o;
   logic       rx_busy_o, rx_int_o;

   int checks = 0;
   int errors = 0;
   int busy_cycles = 0;
   logic [10:0] exp_q[$];

   uart_rx #(.OVERSAMPLE(OS), .PARITY_ODD(ODD)) dut (
      .clk_i        (clk_i),
      .rst_i        (rst_i),
      .rx_i         (rx_i),
      .sample_tick_i(sample_tick_i),
      .crc_en_i     (crc_en_i),
      .data_o       (data_o),
      .parity_err_o (parity_err_o),
      .crc_err_o    (crc_err_o),
      .frame_err_o  (frame_err_o),
      .rx_busy_o    (rx_busy_o),
      .rx_int_o     (rx_int_o)
   );

   always #5 clk_i = ~clk_i;

   always @(negedge clk_i) if (rx_busy_o) busy_cycles++;

   // Remainder of d * x^8 modulo x^8+x^2+x+1.
   function automatic logic [7:0] crc8(input logic [7:0] d);
      logic [15:0] v;
      v = {d, 8'h00};
      for (int i = 15; i >= 8; i--)
         if (v[i]) v = v ^ (16'h0107 << (i - 8));
      return v[7:0];
   endfunction

   function automatic logic good_par(input logic [7:0] d);
      return ^d ^ ODD;
   endfunction

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   task automatic expect_frame(input logic [7:0] d, input logic p,
                               input logic ce, input logic [7:0] c,
                               input logic stop);
      logic pe, ceb;
      pe  = ^d ^ p ^ ODD;
      ceb = ce && (c != crc8(d));
      exp_q.push_back({d, pe, ceb, ~stop});
   endtask

   task automatic drive_slot(input logic b);
      @(posedge clk_i);
      #1;
      rx_i = b;
      sample_tick_i = 1'b1;
      @(posedge clk_i);
      #1;
      sample_tick_i = 1'b0;
      repeat (TDIV - 2) @(posedge clk_i);
   endtask

   // Glitch inverts the one tick slot the receiver treats as mid-bit.
   task automatic drive_bit(input logic b, input bit glitch);
      for (int s = 0; s < OS; s++)
         drive_slot((glitch && s == OS / 2 - 1) ? ~b : b);
   endtask

   task automatic idle_bits(input int n);
      for (int i = 0; i < n; i++) drive_bit(1'b1, 1'b0);
   endtask

   task automatic send_frame(input logic [7:0] d, input logic p,
                             input logic ce, input logic [7:0] c,
                             input logic stop, input bit glitch);
      crc_en_i = ce;
      drive_bit(1'b0, 1'b0);
      for (int i = 0; i < 8; i++) drive_bit(d[i], glitch);
      drive_bit(p, 1'b0);
      if (ce)
         for (int i = 7; i >= 0; i--) drive_bit(c[i], 1'b0);
      drive_bit(stop, 1'b0);
   endtask

   initial begin : monitor
      logic [10:0] e;
      forever begin
         @(negedge clk_i);
         if (rx_int_o) begin
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_int data=%h", data_o);
            end else begin
               e = exp_q.pop_front();
               chk("frame", {21'd0, data_o, parity_err_o,
                             crc_err_o, frame_err_o}, {21'd0, e});
            end
            @(negedge clk_i);
            chk("int_width", {31'd0, rx_int_o}, 32'd0);
         end
      end
   end

   initial begin : stim
      logic [7:0] d, c, ed;
      logic       p, ce, stop;
      int         mark;

      repeat (5) @(posedge clk_i);
      @(negedge clk_i);
      chk("rst_data", {24'd0, data_o}, 32'd0);
      chk("rst_flags", {27'd0, parity_err_o, crc_err_o, frame_err_o,
                        rx_busy_o, rx_int_o}, 32'd0);
      @(posedge clk_i);
      #1;
      rst_i = 1'b1;
      idle_bits(2);

      expect_frame(8'hA5, 1'b0, 1'b0, 8'h00, 1'b1);
      send_frame(8'hA5, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
      idle_bits(1);

      expect_frame(8'h31, good_par(8'h31), 1'b1, 8'h97, 1'b1);
      send_frame(8'h31, good_par(8'h31), 1'b1, 8'h97, 1'b1, 1'b0);
      expect_frame(8'h31, good_par(8'h31), 1'b1, 8'h96, 1'b1);
      send_frame(8'h31, good_par(8'h31), 1'b1, 8'h96, 1'b1, 1'b0);
      idle_bits(1);

      expect_frame(8'h01, 1'b0, 1'b0, 8'h00, 1'b1);
      send_frame(8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
      idle_bits(1);

      expect_frame(8'h55, good_par(8'h55), 1'b0, 8'h00, 1'b0);
      send_frame(8'h55, good_par(8'h55), 1'b0, 8'h00, 1'b0, 1'b0);
      drive_bit(1'b0, 1'b0);
      drive_bit(1'b0, 1'b0);
      idle_bits(2);

      mark = busy_cycles;
      for (int s = 0; s < 4; s++) drive_slot(1'b0);
      idle_bits(2);
      chk("glitch_busy", busy_cycles - mark, 32'd0);

      crc_en_i = 1'b0;
      drive_bit(1'b0, 1'b0);
      for (int i = 0; i < 4; i++) drive_bit(1'b1, 1'b0);
      for (int s = 0; s < 3; s++) drive_slot(1'b0);
      @(negedge clk_i);
      chk("busy_mid", {31'd0, rx_busy_o}, 32'd1);
      rst_i = 1'b0;
      rx_i  = 1'b1;
      #1;
      chk("mid_rst_data", {24'd0, data_o}, 32'd0);
      chk("mid_rst_flags", {27'd0, parity_err_o, crc_err_o, frame_err_o,
                            rx_busy_o, rx_int_o}, 32'd0);
      repeat (3) @(posedge clk_i);
      #1;
      rst_i = 1'b1;
      idle_bits(2);
      expect_frame(8'h3C, good_par(8'h3C), 1'b0, 8'h00, 1'b1);
      send_frame(8'h3C, good_par(8'h3C), 1'b0, 8'h00, 1'b1, 1'b0);
      idle_bits(1);

      for (int n = 0; n < 24; n++) begin
         d    = 8'($urandom);
         ce   = 1'($urandom_range(0, 1));
         p    = good_par(d) ^ ($urandom_range(0, 3) == 0);
         c    = crc8(d);
         if ($urandom_range(0, 3) == 0) c = c ^ 8'($urandom_range(1, 255));
         stop = ($urandom_range(0, 7) != 0);
         expect_frame(d, p, ce, c, stop);
         send_frame(d, p, ce, c, stop, 1'b0);
         if (!stop) idle_bits(1);
         else idle_bits($urandom_range(0, 1));
      end

`ifdef UART_RX_MAJORITY_EN
      ed = 8'hC3;
`else
      ed = 8'h3C;
`endif
      expect_frame(ed, good_par(8'hC3), 1'b0, 8'h00, 1'b1);
      send_frame(8'hC3, good_par(8'hC3), 1'b0, 8'h00, 1'b1, 1'b1);
      idle_bits(1);

      for (int i = 0; i < 4000 && exp_q.size() != 0; i++)
         @(negedge clk_i);
      chk("queue_drain", exp_q.size(), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
